// File: rtl/mem_if_arbiter.sv
// Two-port (fetch/load-store) arbiter onto one req/gnt memory interface with bus lock until grant.
// Define MEM_ARB_DMEM_PRIO_EN to give the d port fixed priority instead of round-robin.
module mem_if_arbiter #(
  parameter int unsigned MEM_ADDR_W = 64,
  parameter int unsigned MEM_DATA_W = 64,
  parameter int unsigned MEM_STRB_W = MEM_DATA_W / 8
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  i_req,
  input  logic [MEM_ADDR_W-1:0] i_addr,
  input  logic                  i_wen,
  input  logic [MEM_STRB_W-1:0] i_strb,
  input  logic [MEM_DATA_W-1:0] i_wdata,
  output logic                  i_gnt,
  output logic                  i_err,
  output logic [MEM_DATA_W-1:0] i_rdata,
  input  logic                  d_req,
  input  logic [MEM_ADDR_W-1:0] d_addr,
  input  logic                  d_wen,
  input  logic [MEM_STRB_W-1:0] d_strb,
  input  logic [MEM_DATA_W-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_err,
  output logic [MEM_DATA_W-1:0] d_rdata,
  output logic                  mem_req,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [MEM_STRB_W-1:0] mem_strb,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_err,
  input  logic [MEM_DATA_W-1:0] mem_rdata
);

  localparam logic [0:0] FREE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic                  wen;
    logic [MEM_STRB_W-1:0] strb;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_cmd_t;

  logic [0:0] lock_q, lock_d;
  logic       sel_q, sel_d;
  logic       last_q, last_d;
  logic       rsp_v_q, rsp_v_d;
  logic       rsp_own_q, rsp_own_d;
  logic       sel;
  logic       acc;
  mem_cmd_t   i_cmd, d_cmd, mem_cmd;

  // Port selection: a locked port keeps the bus until it is granted.
  always_comb begin
    sel = 1'b0;
    if (lock_q == LOCKED) begin
      sel = sel_q;
    end else if (i_req && d_req) begin
`ifdef MEM_ARB_DMEM_PRIO_EN
      sel = 1'b1;
`else
      sel = ~last_q;
`endif
    end else if (d_req) begin
      sel = 1'b1;
    end
  end

  assign i_cmd   = {i_addr, i_wen, i_strb, i_wdata};
  assign d_cmd   = {d_addr, d_wen, d_strb, d_wdata};
  assign mem_cmd = sel ? d_cmd : i_cmd;

  assign mem_req   = g_resetn & (sel ? d_req : i_req);
  assign mem_addr  = mem_cmd.addr;
  assign mem_wen   = mem_cmd.wen;
  assign mem_strb  = mem_cmd.strb;
  assign mem_wdata = mem_cmd.wdata;

  assign acc   = mem_req & mem_gnt;
  assign i_gnt = acc & ~sel;
  assign d_gnt = acc & sel;

  // Responses arrive one cycle after acceptance; rdata is shared, err is steered.
  assign i_err   = mem_err & rsp_v_q & ~rsp_own_q;
  assign d_err   = mem_err & rsp_v_q & rsp_own_q;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  always_comb begin
    lock_d    = lock_q;
    sel_d     = sel_q;
    last_d    = last_q;
    rsp_v_d   = 1'b0;
    rsp_own_d = rsp_own_q;
    case (lock_q)
      FREE: begin
        if (mem_req && !mem_gnt) begin
          lock_d = LOCKED;
          sel_d  = sel;
        end
      end
      LOCKED: begin
        if (mem_gnt) begin
          lock_d = FREE;
        end
      end
      default: lock_d = FREE;
    endcase
    if (acc) begin
      last_d    = sel;
      rsp_v_d   = 1'b1;
      rsp_own_d = sel;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      lock_q    <= FREE;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      rsp_v_q   <= 1'b0;
      rsp_own_q <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      rsp_v_q   <= rsp_v_d;
      rsp_own_q <= rsp_own_d;
    end
  end

endmodule
